psram_access_sched: RTL and testbench
=====================================

// Module: psram_access_sched
// PURPOSE
//  Schedules the single PSRAM controller port between two requesters: video line refill reads
//  (priority) and MCU burst writes from the QSPI memory-mapped write path.
//  Sits between the QSPI write FIFO / video fetch unit and the PSRAM controller, on xClk.
//  Issues one burst command at a time and steers per-word data strobes to the owning requester.
//  Drives xRamReady back to the QSPI write path.
// PARAMETERS
//  ADDR_W    23  PSRAM word address width
//  LEN_W     8   burst length field width (length = words, 1..2^LEN_W-1)
//  WR_LEN    32  fixed MCU write burst length, words
//  VID_LEN   64  fixed video refill burst length, words
//  MAX_WAIT  256 cycles a pending MCU write may wait before it overrides video priority
//  GAP_CYC   2   idle cycles forced between consecutive commands (>=1)
// PORTS
//  xClk         in   1       system clock
//  xRst_n       in   1       asynchronous active-low reset
//  vReq         in   1       video refill request, level, held until vDone
//  vAddr        in   ADDR_W  video burst start address, stable while vReq
//  vDone        out  1       1-cycle pulse: video burst complete
//  vDataValid   out  1       read word valid for video (= pDataStrobe while video owns)
//  wReq         in   1       MCU write request, 1-cycle pulse (end of QSPI CS)
//  wAddr        in   ADDR_W  MCU write start address, sampled on wReq
//  wRdEn        out  1       FIFO pop, one per written word
//  xRamReady    out  1       high = no MCU write pending or active
//  wOvf         out  1       sticky: wReq arrived while a write was already pending/active
//  pCmdValid    out  1       command valid to PSRAM controller
//  pCmdWrite    out  1       1 = write, 0 = read
//  pCmdAddr     out  ADDR_W  command start address
//  pCmdLen      out  LEN_W   command burst length
//  pCmdReady    in   1       controller accepts command when pCmdValid & pCmdReady
//  pDataStrobe  in   1       one word transferred (write consumed / read delivered)
//  pDone        in   1       1-cycle pulse: burst finished
// BEHAVIOUR
//  Reset: all outputs 0, except xRamReady = 1. FSM -> IDLE, pending/wait/word counters cleared.
//   Reset mid-burst abandons the burst; no vDone is issued.
//  wReq latches wPend and wAddr (register, not live input). If wPend or a write is active,
//   the pulse is dropped, wAddr is not re-sampled and wOvf is set (cleared only by reset).
//  xRamReady = ~wPend & ~(owner==W & state!=IDLE). Registered, so it drops the cycle after wReq.
//  Wait counter: increments each cycle wPend is set and the FSM is not serving W; saturates at MAX_WAIT;
//   clears on W grant.
//  FSM states:
//   IDLE -> ISSUE when any request is pending. Decision takes 1 cycle after request visibility.
//     Priority: W if waitCnt==MAX_WAIT, else V if vReq, else W.
//     Owner, pCmdWrite, pCmdAddr and pCmdLen (WR_LEN or VID_LEN) are registered on entry to ISSUE.
//   ISSUE: pCmdValid=1 and held with stable fields until pCmdReady. Accept -> XFER, pCmdValid=0 next cycle.
//   XFER: owner W: wRdEn = pDataStrobe (combinational pass-through).
//     Owner V: vDataValid = pDataStrobe.
//     Word counter counts strobes. pDone -> GAP.
//     If pDone arrives with count != length, the burst still completes; no error is raised.
//     Owner V: vDone pulses the cycle after pDone.
//     Owner W: wPend clears on pDone.
//   GAP: GAP_CYC cycles, no command. -> IDLE.
//  pDataStrobe outside XFER is ignored (no wRdEn/vDataValid).
//  Simultaneous wReq and vReq in IDLE with waitCnt<MAX_WAIT: V wins; W waits, counter runs.
//  Simultaneous wReq and pDone of a W burst: the new pulse is accepted (wPend clears then sets),
//   with no overflow.
//  vReq deasserted before grant: the request is withdrawn, no command is issued.
//   After ISSUE entry the burst completes regardless.
// CONFIGURATION
//  PSRAM_SCHED_STATS_EN defined:
//   adds outputs statVGrants[15:0], statWGrants[15:0], statMaxWait[15:0].
//   Grant counters increment on command acceptance and wrap at 0xFFFF.
//   statMaxWait = largest waitCnt observed at W grant.
//   All cleared by reset.
//  Not defined: these ports and their logic are absent. Scheduling is identical.
// TESTING
//  1 Lone MCU write, wAddr=0x000100: wReq pulse -> xRamReady low next cycle; ISSUE write, addr 0x000100, len 32;
//    32 strobes -> 32 wRdEn; pDone -> xRamReady high after GAP.
//  2 vReq and wReq same cycle -> video read (len 64) issued first; write issued after vDone+GAP; wOvf stays 0.
//  3 vReq held continuously, wReq pending -> at waitCnt=256 the next arbitration grants W
//    even though vReq=1; waitCnt clears.
//  4 pCmdReady low 10 cycles in ISSUE -> pCmdValid/addr/len stable all 10 cycles; accepted on cycle 11.
//  5 Second wReq during an active write -> wOvf=1, wAddr unchanged, no extra burst issued.
//  6 xRst_n low mid-XFER (video, 20 words) -> outputs reset immediately, xRamReady=1, no vDone;
//    after release a fresh vReq is served from IDLE. With PSRAM_SCHED_STATS_EN, counters read 0.

Source files
------------

// File: rtl/psram_access_sched_if.sv
// Requester/controller bundle around the PSRAM access scheduler.
// master: the scheduler side; slave: requesters plus PSRAM controller.
interface psram_access_sched_if #(
  parameter int ADDR_W = 23,
  parameter int LEN_W  = 8
);
  logic              vReq;
  logic [ADDR_W-1:0] vAddr;
  logic              vDone;
  logic              vDataValid;
  logic              wReq;
  logic [ADDR_W-1:0] wAddr;
  logic              wRdEn;
  logic              xRamReady;
  logic              wOvf;
  logic              pCmdValid;
  logic              pCmdWrite;
  logic [ADDR_W-1:0] pCmdAddr;
  logic [LEN_W-1:0]  pCmdLen;
  logic              pCmdReady;
  logic              pDataStrobe;
  logic              pDone;

  modport master (
    input  vReq, vAddr, wReq, wAddr, pCmdReady, pDataStrobe, pDone,
    output vDone, vDataValid, wRdEn, xRamReady, wOvf,
           pCmdValid, pCmdWrite, pCmdAddr, pCmdLen
  );

  modport slave (
    output vReq, vAddr, wReq, wAddr, pCmdReady, pDataStrobe, pDone,
    input  vDone, vDataValid, wRdEn, xRamReady, wOvf,
           pCmdValid, pCmdWrite, pCmdAddr, pCmdLen
  );
endinterface

// File: rtl/psram_access_sched.sv
// Arbitrates the single PSRAM command port between video refill reads and MCU burst writes.
// Optional grant/wait statistics outputs are enabled by defining PSRAM_SCHED_STATS_EN.
module psram_access_sched #(
  parameter int ADDR_W   = 23,
  parameter int LEN_W    = 8,
  parameter int WR_LEN   = 32,
  parameter int VID_LEN  = 64,
  parameter int MAX_WAIT = 256,
  parameter int GAP_CYC  = 2
) (
  input  logic xClk,
  input  logic xRst_n,
  psram_access_sched_if.master bus
`ifdef PSRAM_SCHED_STATS_EN
  ,
  output logic [15:0] statVGrants,
  output logic [15:0] statWGrants,
  output logic [15:0] statMaxWait
`endif
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int GAP_W  = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, XFER, GAP} state_t;
  typedef enum logic {OWN_V, OWN_W} owner_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } cmd_t;

  state_t            state, state_nxt;
  owner_t            owner, owner_nxt;
  cmd_t              cmd, cmd_nxt;
  logic [GAP_W-1:0]  gap_cnt, gap_cnt_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic [ADDR_W-1:0] w_addr_q;
  logic              w_pend, w_pend_nxt;
  logic              ram_ready_q, v_done_q, w_ovf_q;
  logic              w_busy, w_done, v_done_now, w_accept, wait_max, grant_w;
  logic              cmd_valid, wr_en, vid_valid;

  // A write is "busy" from grant until the post-burst gap drains.
  always_comb begin
    w_busy     = (owner == OWN_W) && (state != IDLE);
    w_done     = (state == XFER) && (owner == OWN_W) && bus.pDone;
    v_done_now = (state == XFER) && (owner == OWN_V) && bus.pDone;
    w_accept   = bus.wReq && (!(w_pend || w_busy) || w_done);
    wait_max   = (wait_cnt == WAIT_W'(MAX_WAIT));
    w_pend_nxt = w_accept ? 1'b1 : (w_done ? 1'b0 : w_pend);
  end

  always_comb begin
    state_nxt   = state;
    owner_nxt   = owner;
    cmd_nxt     = cmd;
    gap_cnt_nxt = gap_cnt;
    grant_w     = 1'b0;
    cmd_valid   = 1'b0;
    wr_en       = 1'b0;
    vid_valid   = 1'b0;
    case (state)
      IDLE: begin
        // Starved writes override video; otherwise video has priority.
        if (w_pend && wait_max) begin
          grant_w = 1'b1;
        end else if (bus.vReq) begin
          state_nxt = ISSUE;
          owner_nxt = OWN_V;
          cmd_nxt   = '{write: 1'b0, addr: bus.vAddr, len: LEN_W'(VID_LEN)};
        end else if (w_pend) begin
          grant_w = 1'b1;
        end
        if (grant_w) begin
          state_nxt = ISSUE;
          owner_nxt = OWN_W;
          cmd_nxt   = '{write: 1'b1, addr: w_addr_q, len: LEN_W'(WR_LEN)};
        end
      end
      ISSUE: begin
        cmd_valid = 1'b1;
        if (bus.pCmdReady) state_nxt = XFER;
      end
      XFER: begin
        wr_en     = bus.pDataStrobe && (owner == OWN_W);
        vid_valid = bus.pDataStrobe && (owner == OWN_V);
        if (bus.pDone) begin
          state_nxt   = GAP;
          gap_cnt_nxt = '0;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_W'(GAP_CYC - 1)) state_nxt = IDLE;
        else gap_cnt_nxt = gap_cnt + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wait_cnt_nxt = wait_cnt;
    if (grant_w) wait_cnt_nxt = '0;
    else if (w_pend && !w_busy && !wait_max) wait_cnt_nxt = wait_cnt + 1'b1;
  end

  always_ff @(posedge xClk or negedge xRst_n) begin
    if (!xRst_n) begin
      state       <= IDLE;
      owner       <= OWN_V;
      cmd         <= '0;
      gap_cnt     <= '0;
      wait_cnt    <= '0;
      w_addr_q    <= '0;
      w_pend      <= 1'b0;
      ram_ready_q <= 1'b1;
      v_done_q    <= 1'b0;
      w_ovf_q     <= 1'b0;
    end else begin
      state       <= state_nxt;
      owner       <= owner_nxt;
      cmd         <= cmd_nxt;
      gap_cnt     <= gap_cnt_nxt;
      wait_cnt    <= wait_cnt_nxt;
      w_pend      <= w_pend_nxt;
      if (w_accept) w_addr_q <= bus.wAddr;
      ram_ready_q <= !w_pend_nxt && !((owner_nxt == OWN_W) && (state_nxt != IDLE));
      v_done_q    <= v_done_now;
      w_ovf_q     <= w_ovf_q || (bus.wReq && !w_accept);
    end
  end

`ifdef PSRAM_SCHED_STATS_EN
  always_ff @(posedge xClk or negedge xRst_n) begin
    if (!xRst_n) begin
      statVGrants <= '0;
      statWGrants <= '0;
      statMaxWait <= '0;
    end else begin
      if (cmd_valid && bus.pCmdReady) begin
        if (owner == OWN_W) statWGrants <= statWGrants + 16'd1;
        else                statVGrants <= statVGrants + 16'd1;
      end
      if (grant_w && (16'(wait_cnt) > statMaxWait)) statMaxWait <= 16'(wait_cnt);
    end
  end
`endif

  assign bus.pCmdValid  = cmd_valid;
  assign bus.pCmdWrite  = cmd.write;
  assign bus.pCmdAddr   = cmd.addr;
  assign bus.pCmdLen    = cmd.len;
  assign bus.wRdEn      = wr_en;
  assign bus.vDataValid = vid_valid;
  assign bus.vDone      = v_done_q;
  assign bus.xRamReady  = ram_ready_q;
  assign bus.wOvf       = w_ovf_q;

endmodule

// File: tb/tb_psram_access_sched.sv
// Directed bench for psram_access_sched: arbitration, handshake hold, overflow, reset.
module tb_psram_access_sched;
  logic xClk, xRst_n;
  int   n_chk, n_err;

  psram_access_sched_if #(.ADDR_W(23), .LEN_W(8)) bus ();

`ifdef PSRAM_SCHED_STATS_EN
  logic [15:0] stat_v, stat_w, stat_max;
`endif

  psram_access_sched dut (
    .xClk   (xClk),
    .xRst_n (xRst_n),
    .bus    (bus.master)
`ifdef PSRAM_SCHED_STATS_EN
    ,
    .statVGrants (stat_v),
    .statWGrants (stat_w),
    .statMaxWait (stat_max)
`endif
  );

  initial xClk = 1'b0;
  always #5 xClk = ~xClk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge xClk);
  endtask

  task automatic wait_cmd(input string tag);
    int k;
    k = 0;
    while (!bus.pCmdValid && k < 20) begin
      tick();
      k++;
    end
    check(tag, 32'(bus.pCmdValid), 32'd1);
  endtask

  int nw, nv, rounds;
  logic got_w;

  initial begin
    n_chk = 0; n_err = 0;
    xRst_n = 1'b0;
    bus.vReq = 0; bus.vAddr = '0; bus.wReq = 0; bus.wAddr = '0;
    bus.pCmdReady = 0; bus.pDataStrobe = 0; bus.pDone = 0;
    tick(); tick();
    check("rst_ready", 32'(bus.xRamReady), 32'd1);
    check("rst_outs", {27'd0, bus.pCmdValid, bus.vDone, bus.wRdEn, bus.vDataValid, bus.wOvf}, 32'd0);
    xRst_n = 1'b1;
    tick();

    // 1: lone MCU write
    bus.wAddr = 23'h000100; bus.wReq = 1; tick(); bus.wReq = 0;
    check("t1_ready_low", 32'(bus.xRamReady), 32'd0);
    check("t1_no_cmd_yet", 32'(bus.pCmdValid), 32'd0);
    tick();
    check("t1_cmd", {bus.pCmdValid, bus.pCmdWrite, bus.pCmdAddr, 7'd0}, {1'b1, 1'b1, 23'h000100, 7'd0});
    check("t1_len", 32'(bus.pCmdLen), 32'd32);
    bus.pCmdReady = 1; tick(); bus.pCmdReady = 0;
    check("t1_valid_drop", 32'(bus.pCmdValid), 32'd0);
    nw = 0; nv = 0;
    repeat (32) begin
      bus.pDataStrobe = 1; #1;
      nw += int'(bus.wRdEn); nv += int'(bus.vDataValid);
      tick();
    end
    bus.pDataStrobe = 0;
    check("t1_wrden_cnt", 32'(nw), 32'd32);
    check("t1_vvalid_cnt", 32'(nv), 32'd0);
    bus.pDone = 1; tick(); bus.pDone = 0;
    check("t1_ready_gap0", 32'(bus.xRamReady), 32'd0);
    tick();
    check("t1_ready_gap1", 32'(bus.xRamReady), 32'd0);
    tick();
    check("t1_ready_idle", 32'(bus.xRamReady), 32'd1);
    bus.pDataStrobe = 1; #1;
    check("t1_stray_strobe", {30'd0, bus.wRdEn, bus.vDataValid}, 32'd0);
    tick(); bus.pDataStrobe = 0;

    // 2: simultaneous video and write requests, video first
    bus.vAddr = 23'h002000; bus.vReq = 1; bus.wAddr = 23'h000300; bus.wReq = 1;
    tick(); bus.wReq = 0;
    check("t2_vcmd", {bus.pCmdValid, bus.pCmdWrite, bus.pCmdAddr, 7'd0}, {1'b1, 1'b0, 23'h002000, 7'd0});
    check("t2_vlen", 32'(bus.pCmdLen), 32'd64);
    bus.pCmdReady = 1; tick(); bus.pCmdReady = 0;
    nw = 0; nv = 0;
    repeat (64) begin
      bus.pDataStrobe = 1; #1;
      nw += int'(bus.wRdEn); nv += int'(bus.vDataValid);
      tick();
    end
    bus.pDataStrobe = 0;
    check("t2_vvalid_cnt", 32'(nv), 32'd64);
    check("t2_wrden_cnt", 32'(nw), 32'd0);
    bus.pDone = 1; tick(); bus.pDone = 0;
    check("t2_vdone", 32'(bus.vDone), 32'd1);
    bus.vReq = 0; tick();
    check("t2_vdone_pulse", 32'(bus.vDone), 32'd0);
    tick(); tick();
    check("t2_wcmd", {bus.pCmdValid, bus.pCmdWrite, bus.pCmdAddr, 7'd0}, {1'b1, 1'b1, 23'h000300, 7'd0});
    check("t2_no_ovf", 32'(bus.wOvf), 32'd0);
    bus.pCmdReady = 1; tick(); bus.pCmdReady = 0;
    bus.pDone = 1; tick(); bus.pDone = 0;   // short burst, no strobes
    check("t2_no_vdone_w", 32'(bus.vDone), 32'd0);
    tick(); tick();
    check("t2_ready_idle", 32'(bus.xRamReady), 32'd1);

    // 3: starvation override with vReq held
    bus.vAddr = 23'h004000; bus.vReq = 1; bus.wAddr = 23'h000500; bus.wReq = 1;
    tick(); bus.wReq = 0;
    nv = 0; got_w = 0; rounds = 0;
    while (!got_w && rounds < 60) begin
      wait_cmd("t3_cmd_timeout");
      if (bus.pCmdWrite) begin
        got_w = 1;
        bus.vReq = 0;
        check("t3_waddr", 32'(bus.pCmdAddr), 32'h000500);
      end else begin
        nv++;
      end
      bus.pCmdReady = 1; tick(); bus.pCmdReady = 0;
      bus.pDone = 1; tick(); bus.pDone = 0;
      rounds++;
    end
    check("t3_v_bursts", 32'(nv), 32'd52);
    check("t3_w_granted", 32'(got_w), 32'd1);
`ifdef PSRAM_SCHED_STATS_EN
    check("t3_stat_maxwait", 32'(stat_max), 32'd256);
`endif
    tick(); tick();
    check("t3_ready_idle", 32'(bus.xRamReady), 32'd1);

    // 4: command held while controller stalls; withdrawal semantics
    bus.vAddr = 23'h012345; bus.vReq = 1; tick();
    bus.vReq = 0;
    for (int i = 0; i < 10; i++) begin
      check("t4_hold", {bus.pCmdValid, bus.pCmdAddr, bus.pCmdLen}, {1'b1, 23'h012345, 8'd64});
      tick();
    end
    bus.pCmdReady = 1;
    check("t4_hold_c11", {bus.pCmdValid, bus.pCmdAddr, bus.pCmdLen}, {1'b1, 23'h012345, 8'd64});
    tick(); bus.pCmdReady = 0;
    check("t4_accepted", 32'(bus.pCmdValid), 32'd0);
    bus.pDone = 1; tick(); bus.pDone = 0;
    check("t4_vdone", 32'(bus.vDone), 32'd1);
    bus.vReq = 1; tick(); bus.vReq = 0;
    tick();
    check("t4_withdrawn_a", 32'(bus.pCmdValid), 32'd0);
    tick();
    check("t4_withdrawn_b", 32'(bus.pCmdValid), 32'd0);

    // 5a: new wReq coincident with write pDone is accepted
    bus.wAddr = 23'h0005A0; bus.wReq = 1; tick(); bus.wReq = 0; tick();
    check("t5a_addr1", 32'(bus.pCmdAddr), 32'h0005A0);
    bus.pCmdReady = 1; tick(); bus.pCmdReady = 0;
    bus.pDone = 1; bus.wReq = 1; bus.wAddr = 23'h000600; tick();
    bus.pDone = 0; bus.wReq = 0;
    check("t5a_no_ovf", 32'(bus.wOvf), 32'd0);
    check("t5a_ready_low", 32'(bus.xRamReady), 32'd0);
    tick(); tick(); tick();
    check("t5a_second", {bus.pCmdValid, bus.pCmdWrite, bus.pCmdAddr, 7'd0}, {1'b1, 1'b1, 23'h000600, 7'd0});
    bus.pCmdReady = 1; tick(); bus.pCmdReady = 0;
    bus.pDone = 1; tick(); bus.pDone = 0; tick(); tick();

    // 5b: overflow while pending and while active
    bus.vAddr = 23'h007000; bus.vReq = 1; bus.wAddr = 23'h000ABC; bus.wReq = 1; tick();
    bus.wAddr = 23'h000DEF; tick(); bus.wReq = 0;
    check("t5b_ovf", 32'(bus.wOvf), 32'd1);
    bus.pCmdReady = 1; tick(); bus.pCmdReady = 0;
    bus.pDone = 1; tick(); bus.pDone = 0; bus.vReq = 0;
    tick(); tick(); tick();
    check("t5b_waddr_kept", {bus.pCmdValid, bus.pCmdWrite, bus.pCmdAddr, 7'd0}, {1'b1, 1'b1, 23'h000ABC, 7'd0});
    bus.wAddr = 23'h000111; bus.wReq = 1; tick(); bus.wReq = 0;
    check("t5b_ovf_sticky", 32'(bus.wOvf), 32'd1);
    bus.pCmdReady = 1; tick(); bus.pCmdReady = 0;
    bus.pDone = 1; tick(); bus.pDone = 0; tick(); tick(); tick();
    check("t5b_no_extra", {30'd0, bus.pCmdValid, bus.xRamReady}, 32'd1);

    // 6: reset mid video transfer
    bus.vAddr = 23'h000100; bus.vReq = 1; tick();
    bus.pCmdReady = 1; tick(); bus.pCmdReady = 0;
    repeat (20) begin bus.pDataStrobe = 1; tick(); end
    bus.pDataStrobe = 0;
    xRst_n = 1'b0; #1;
    check("t6_rst_outs", {27'd0, bus.pCmdValid, bus.vDone, bus.wRdEn, bus.vDataValid, bus.wOvf}, 32'd0);
    check("t6_rst_ready", 32'(bus.xRamReady), 32'd1);
    check("t6_rst_cmd", {bus.pCmdWrite, bus.pCmdAddr, bus.pCmdLen}, 32'd0);
`ifdef PSRAM_SCHED_STATS_EN
    check("t6_stats_zero", {stat_v, stat_w | stat_max}, 32'd0);
`endif
    tick(); xRst_n = 1'b1;
    check("t6_no_vdone", 32'(bus.vDone), 32'd0);
    tick();
    check("t6_fresh_cmd", {bus.pCmdValid, bus.pCmdWrite, bus.pCmdAddr, 7'd0}, {1'b1, 1'b0, 23'h000100, 7'd0});
    check("t6_no_vdone2", 32'(bus.vDone), 32'd0);
    bus.pCmdReady = 1; tick(); bus.pCmdReady = 0;
    bus.pDone = 1; tick(); bus.pDone = 0; bus.vReq = 0;
    check("t6_vdone", 32'(bus.vDone), 32'd1);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
